des_decrypt_iter: RTL

- Iterative single-DES decryption engine. It recovers a 64-bit plaintext block from ciphertext using one Feistel round per clock.
- Reuses the existing `round` module and applies the subkeys in reverse order, K16 down to K1. The reverse schedule is generated on the fly by right-rotating C/D.
- It is the decrypt-direction counterpart of the encryption datapath. It is the building block for the Triple-DES D stages (E-D-E / D-E-D).

---
 rtl/des_pkg.sv | 181 ++++++++++++++++++
 rtl/round.sv | 27 ++
 rtl/des_decrypt_iter.sv | 110 +++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// DES constants and permutation helpers.
// Shared by the iterative decrypt engine and its round.
package des_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int ROUNDS = 16;

  localparam int IP_T [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25
  };

  localparam int PC1_T [1:56] = '{
    57, 49, 41, 33, 25, 17, 9,
    1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
    7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29,
    21, 13, 5, 28, 20, 12, 4
  };

  localparam int PC2_T [1:48] = '{
    14, 17, 11, 24, 1, 5,
    3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8,
    16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int E_T [1:48] = '{
    32, 1, 2, 3, 4, 5,
    4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32, 1
  };

  localparam int P_T [1:32] = '{
    16, 7, 20, 21, 29, 12, 28, 17,
    1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9,
    19, 13, 30, 6, 22, 11, 4, 25
  };

  // Eight boxes, 64 entries each, row-major (row*16 + col).
  localparam int SBOX [0:511] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
  };

  // Right-rotation applied before round k of decryption.
  localparam int RSH [1:16] = '{
    0, 1, 2, 2, 2, 2, 2, 2,
    1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic logic [1:64] ip(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i]];
    return y;
  endfunction

  function automatic logic [1:64] fp(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[FP_T[i]];
    return y;
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 1; i <= 56; i++) y[i] = x[PC1_T[i]];
    return y;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = x[PC2_T[i]];
    return y;
  endfunction

  function automatic logic [1:48] e_exp(input logic [1:32] x);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = x[E_T[i]];
    return y;
  endfunction

  function automatic logic [1:32] p_perm(input logic [1:32] x);
    logic [1:32] y;
    for (int i = 1; i <= 32; i++) y[i] = x[P_T[i]];
    return y;
  endfunction

  // Row from outer bits 1/6, column from inner bits 2..5.
  function automatic logic [1:4] sbox(
    input int b,
    input logic [1:6] x
  );
    int idx;
    idx = 64 * b + int'({x[1], x[6], x[2:5]});
    return 4'(SBOX[idx]);
  endfunction

  function automatic logic [1:28] rotr(
    input logic [1:28] x,
    input logic [1:0] n
  );
    logic [1:28] y;
    case (n)
      2'd1: y = {x[28], x[1:27]};
      2'd2: y = {x[27:28], x[1:26]};
      default: y = x;
    endcase
    return y;
  endfunction

  // Rotation after round k; the extra 1 at the end restores PC1(key).
  function automatic logic [1:0] rot_amt(input logic [4:0] k);
    if (k >= 5'(ROUNDS)) return 2'd1;
    return 2'(RSH[int'(k) + 1]);
  endfunction

endpackage

// File: rtl/round.sv
// One DES Feistel round: f-function on R, xor into L, swap.
// Purely combinational; the caller registers L/R.
module round
  import des_pkg::*;
(
  input  logic [1:32] l_in,
  input  logic [1:32] r_in,
  input  logic [1:48] subkey,
  output logic [1:32] l_out,
  output logic [1:32] r_out
);

  logic [1:48] x;
  logic [1:32] s;

  // Expand, key-mix, substitute, permute, then swap halves.
  always_comb begin
    s = '0;
    x = e_exp(r_in) ^ subkey;
    for (int b = 0; b < 8; b++) begin
      s[4*b+1 +: 4] = sbox(b, x[6*b+1 +: 6]);
    end
    l_out = r_in;
    r_out = l_in ^ p_perm(s);
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative single-DES decryption, one round per clock.
// Subkeys K16..K1 come from right-rotating C/D on the fly.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:64] data_in,
  input  logic [1:64] key_in,
  output logic        busy,
  output logic        done,
  output logic [1:64] data_out
);

  state_t      state;
  state_t      state_nx;
  logic        load;
  logic        step;
  logic        last;
  logic [1:32] l;
  logic [1:32] r;
  logic [1:32] l_nx;
  logic [1:32] r_nx;
  logic [1:28] c;
  logic [1:28] d;
  logic [4:0]  cnt;
  logic [1:48] subkey;
  logic [1:0]  rot;

  assign subkey = pc2({c, d});
  assign rot    = rot_amt(cnt);

  round u_round (
    .l_in  (l),
    .r_in  (r),
    .subkey(subkey),
    .l_out (l_nx),
    .r_out (r_nx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == 5'(ROUNDS)) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  // Load on accept, one round per RUN cycle, publish on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      l        <= '0;
      r        <= '0;
      c        <= '0;
      d        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        load: begin
          {l, r} <= ip(data_in);
          {c, d} <= pc1(key_in);
          cnt    <= 5'd1;
          busy   <= 1'b1;
        end
        step: begin
          l <= l_nx;
          r <= r_nx;
          c <= rotr(c, rot);
          d <= rotr(d, rot);
          if (last) begin
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            data_out <= fp({r_nx, l_nx});
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
